// File: rtl/ast_pkg.sv
// Shared types and helpers for the Avalon-ST packet transmitter.
//   state_t : transmitter FSM state encoding
//   cnt_w   : width needed to count 0..max_len inclusive
package ast_pkg;

    typedef enum logic [1:0] {
        IDLE_S    = 2'd0,
        LOADING_S = 2'd1,
        SENDING_S = 2'd2
    } state_t;

    function automatic int cnt_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/pkt_buffer.sv
// Packet storage: DEPTH x DWIDTH register array.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : combinational read address
//   rdata : combinational read data
// Contents are intentionally not reset.
module pkt_buffer #(
    parameter int DWIDTH = 10,
    parameter int DEPTH  = 10,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ast_pkt_transmitter.sv
// Avalon-ST packet source. A producer loads one packet through a
// valid/ready/last write port; the packet is then replayed on an
// Avalon-ST source with sop/eop framing under src_ready_i backpressure.
//   clk_i, arst_i        : clock, asynchronous active-high reset
//   wr_data_i/valid/last : load port, wr_ready_o high when not sending
//   src_*                : Avalon-ST source (data, sop, eop, valid, ready)
//   pkt_trunc_o          : one-cycle pulse when a load hit MAX_PKT_LEN
//                          without wr_last_i
//   busy_o               : high while the packet is being sent
module ast_pkt_transmitter
    import ast_pkg::*;
#(
    parameter int DWIDTH      = 10,
    parameter int MAX_PKT_LEN = 10
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic              wr_valid_i,
    input  logic              wr_last_i,
    output logic              wr_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              pkt_trunc_o,
    output logic              busy_o
);

    localparam int CNT_W = cnt_w(MAX_PKT_LEN);

    state_t            state, next_state;
    logic [CNT_W-1:0]  wr_ptr, rd_ptr, len;
    logic [DWIDTH-1:0] rdata;
    logic              accept;
    logic              at_limit;
    logic              load_end;
    logic              trunc_set;
    logic              eop;

    pkt_buffer #(
        .DWIDTH (DWIDTH),
        .DEPTH  (MAX_PKT_LEN),
        .AW     (CNT_W)
    ) u_buf (
        .clk   (clk_i),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (wr_data_i),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign wr_ready_o = (state != SENDING_S) && !arst_i;
    assign accept     = wr_valid_i && wr_ready_o;
    assign at_limit   = (wr_ptr == CNT_W'(MAX_PKT_LEN - 1));
    assign eop        = (rd_ptr == len - CNT_W'(1));

    always_comb begin
        next_state          = state;
        load_end            = 1'b0;
        trunc_set           = 1'b0;
        src_valid_o         = 1'b0;
        src_startofpacket_o = 1'b0;
        src_endofpacket_o   = 1'b0;
        src_data_o          = '0;
        busy_o              = 1'b0;
        case (state)
            IDLE_S, LOADING_S: begin
                // The limit check also covers MAX_PKT_LEN == 1 from IDLE_S.
                if (accept) begin
                    if (wr_last_i || at_limit) begin
                        next_state = SENDING_S;
                        load_end   = 1'b1;
                        trunc_set  = !wr_last_i;
                    end else begin
                        next_state = LOADING_S;
                    end
                end
            end
            SENDING_S: begin
                src_valid_o         = 1'b1;
                src_data_o          = rdata;
                src_startofpacket_o = (rd_ptr == '0);
                src_endofpacket_o   = eop;
                busy_o              = 1'b1;
                if (src_ready_i && eop) begin
                    next_state = IDLE_S;
                end
            end
            default: begin
                next_state          = state_t'('x);
                src_valid_o         = 1'bx;
                src_startofpacket_o = 1'bx;
                src_endofpacket_o   = 1'bx;
                src_data_o          = 'x;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state       <= IDLE_S;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            len         <= '0;
            pkt_trunc_o <= 1'b0;
        end else begin
            assert (state inside {IDLE_S, LOADING_S, SENDING_S});
            state       <= next_state;
            pkt_trunc_o <= trunc_set;
            if (accept) begin
                wr_ptr <= wr_ptr + CNT_W'(1);
            end
            if (load_end) begin
                len <= wr_ptr + CNT_W'(1);
            end
            if (state == SENDING_S && src_ready_i) begin
                if (eop) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    len    <= '0;
                end else begin
                    rd_ptr <= rd_ptr + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ast_pkt_transmitter.sv
module tb_ast_pkt_transmitter;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_last = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] src_data;
    logic          src_sop, src_eop, src_valid;
    logic          src_ready = 1'b0;
    logic          pkt_trunc;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] ld [16];
    logic [DW-1:0] ex [16];

    always #5 clk = ~clk;

    ast_pkt_transmitter #(
        .DWIDTH      (DW),
        .MAX_PKT_LEN (10)
    ) dut (
        .clk_i               (clk),
        .arst_i              (arst),
        .wr_data_i           (wr_data),
        .wr_valid_i          (wr_valid),
        .wr_last_i           (wr_last),
        .wr_ready_o          (wr_ready),
        .src_data_o          (src_data),
        .src_startofpacket_o (src_sop),
        .src_endofpacket_o   (src_eop),
        .src_valid_o         (src_valid),
        .src_ready_i         (src_ready),
        .pkt_trunc_o         (pkt_trunc),
        .busy_o              (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents ld[0..n-1]; returns just after the edge accepting the final word.
    task automatic load(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_data  = ld[i];
            wr_valid = 1'b1;
            wr_last  = with_last && (i == n - 1);
            check("ld_ready", {31'd0, wr_ready}, 32'd1);
            check("ld_no_beat", {31'd0, src_valid}, 32'd0);
            @(posedge clk);
        end
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Collects beats with src_ready following pat; returns just after the eop transfer edge.
    task automatic drain(input int n, input logic [7:0] pat, input int plen);
        int            k;
        bit            done;
        bit            stalled;
        logic [DW+1:0] prev;
        k = 0;
        done = 1'b0;
        stalled = 1'b0;
        prev = '0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            src_ready = pat[c % plen];
            if (c == 0) check("first_valid", {31'd0, src_valid}, 32'd1);
            if (stalled) check("hold", {20'd0, src_data, src_sop, src_eop}, {20'd0, prev});
            stalled = src_valid && !src_ready;
            prev = {src_data, src_sop, src_eop};
            if (src_valid && src_ready) begin
                if (k < n) begin
                    check("beat_data", {22'd0, src_data}, {22'd0, ex[k]});
                    check("beat_sop", {31'd0, src_sop}, {31'd0, k == 0});
                    check("beat_eop", {31'd0, src_eop}, {31'd0, k == n - 1});
                end else begin
                    check("extra_beat", 32'd1, 32'd0);
                end
                k++;
                if (src_eop) begin
                    @(posedge clk);
                    done = 1'b1;
                end
            end
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        check("beat_count", k, n);
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("idle_valid", {31'd0, src_valid}, 32'd0);
        check("idle_data", {22'd0, src_data}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_ready", {31'd0, wr_ready}, 32'd1);
    endtask

    initial begin
        int pulses;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, src_valid}, 32'd0);
        check("rst_sop", {31'd0, src_sop}, 32'd0);
        check("rst_eop", {31'd0, src_eop}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", {22'd0, src_data}, 32'd0);
        check("rst_trunc", {31'd0, pkt_trunc}, 32'd0);
        arst = 1'b0;
        #1;
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);

        // 1: three words, full-rate drain
        ld[0] = 10'h005; ld[1] = 10'h00A; ld[2] = 10'h3FF;
        ex[0] = 10'h005; ex[1] = 10'h00A; ex[2] = 10'h3FF;
        src_ready = 1'b1;
        load(3, 1'b1);
        drain(3, 8'hFF, 1);
        idle_check();

        // 2: single-word packet
        ld[0] = 10'h123; ex[0] = 10'h123;
        load(1, 1'b1);
        drain(1, 8'hFF, 1);
        idle_check();

        // 3: backpressure pattern 1,0,0,1,1,0,1
        for (int i = 0; i < 4; i++) begin
            ld[i] = DW'(i + 1);
            ex[i] = DW'(i + 1);
        end
        load(4, 1'b1);
        drain(4, 8'b0101_1001, 7);
        idle_check();

        // 4: truncation at MAX_PKT_LEN
        src_ready = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            wr_data  = DW'(i + 1);
            wr_valid = 1'b1;
            wr_last  = 1'b0;
            check("t4_ready", {31'd0, wr_ready}, {31'd0, i < 10});
            if (pkt_trunc) pulses++;
            if (i == 10) begin
                check("t4_trunc", {31'd0, pkt_trunc}, 32'd1);
                check("t4_busy", {31'd0, busy}, 32'd1);
            end
            @(posedge clk);
        end
        #1;
        wr_valid = 1'b0;
        check("t4_pulses", pulses, 32'd1);
        for (int i = 0; i < 10; i++) ex[i] = DW'(i + 1);
        drain(10, 8'hFF, 1);
        idle_check();

        // 5: asynchronous reset mid-send
        for (int i = 0; i < 5; i++) ld[i] = DW'(20 + i);
        load(5, 1'b1);
        @(negedge clk);
        src_ready = 1'b1;
        check("t5_beat0", {22'd0, src_data}, 32'd20);
        @(posedge clk);
        @(negedge clk);
        check("t5_beat1", {22'd0, src_data}, 32'd21);
        @(posedge clk);
        #2;
        arst = 1'b1;
        #1;
        check("t5_rst_valid", {31'd0, src_valid}, 32'd0);
        check("t5_rst_data", {22'd0, src_data}, 32'd0);
        check("t5_rst_sop", {31'd0, src_sop}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        arst = 1'b0;
        #1;
        check("t5_wr_ready", {31'd0, wr_ready}, 32'd1);
        ld[0] = 10'd7; ld[1] = 10'd8;
        ex[0] = 10'd7; ex[1] = 10'd8;
        load(2, 1'b1);
        drain(2, 8'hFF, 1);
        idle_check();

        // 6: back-to-back, B loaded in the idle cycle after A's eop
        ld[0] = 10'h0AA; ld[1] = 10'h0BB;
        ex[0] = 10'h0AA; ex[1] = 10'h0BB;
        load(2, 1'b1);
        drain(2, 8'hFF, 1);
        ld[0] = 10'h111; ld[1] = 10'h222; ld[2] = 10'h333;
        ex[0] = 10'h111; ex[1] = 10'h222; ex[2] = 10'h333;
        load(3, 1'b1);
        drain(3, 8'hFF, 1);
        idle_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
